serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
- Receiver end of the single-bit serial line driven by the team's one-output FSM generators on the `q` pin.
- Samples one bit per `clk`, recognises start/data/stop framing, and deserialises data bits LSB first into a parallel word.
- Presents the word through a one-entry valid/ready holding register. Framing errors and overruns are reported as one-cycle pulses.
- Sits between a serial-output FSM and any parallel consumer, e.g. a Brainfuck input-port model.

Parameters:
- DATA_BITS, 8, number of data bits per frame (1..16).
- START_LEVEL, 1, line level that marks a start bit. Idle line is the inverse.
- STOP_LEVEL, 0, required line level of the stop bit.

Ports:
- clk  input  1  system clock. All sampling on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- d  input  1  serial line, one bit per clock. Driven synchronously to clk.
- data_out  output  DATA_BITS  received word. Stable while valid=1.
- valid  output  1  data_out holds an unconsumed word.
- ready  input  1  consumer accepts the word on a rising edge where valid&ready.
- frame_err  output  1  one-cycle pulse: stop bit did not equal STOP_LEVEL, frame discarded.
- overrun  output  1  one-cycle pulse: good frame completed while holding register full and not draining, frame discarded.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE, bit counter=0, shift register=0.
  - data_out=0, valid=0, frame_err=0, overrun=0.
  - A partial frame is lost; no pulse is generated for it.
- States are IDLE, DATA and STOP. Bit counter width is $clog2(DATA_BITS+1).
- IDLE:
  - d==START_LEVEL at an edge -> DATA, counter=0.
  - Otherwise stay in IDLE.
- DATA:
  - Each edge writes d into shift bit [counter] (LSB first) and increments counter.
  - When counter reaches DATA_BITS-1 and that bit is captured -> STOP.
- STOP, evaluated at one edge, then -> IDLE:
  - d!=STOP_LEVEL: frame_err=1 for exactly one cycle. Holding register unchanged.
  - d==STOP_LEVEL and (valid==0 or ready==1): data_out<=shift, valid<=1.
  - d==STOP_LEVEL and valid==1 and ready==0: overrun=1 for one cycle. data_out and valid unchanged; the old word is kept.
- Timing:
  - Latency: start bit sampled at edge k, data at edges k+1..k+DATA_BITS, stop at edge k+DATA_BITS+1.
  - valid rises after edge k+DATA_BITS+1.
  - Back-to-back frames: the next start bit is accepted at edge k+DATA_BITS+2 (first IDLE edge). The minimum frame period is DATA_BITS+2 cycles.
- Handshake:
  - valid&ready at an edge with no load -> valid=0 next cycle. data_out retains its last value.
  - Simultaneous drain and load at the same edge -> valid stays 1 and data_out takes the new word. No bubble, no overrun.
  - ready while valid=0 has no effect.
- A start-level bit during DATA is data, not a resync. There is no mid-frame abort other than rst.
- frame_err and overrun are never high in the same cycle. Both are registered outputs.

Test Plan:
1. Reset, then d=1; 1,0,1,0,0,1,0,1; 0 with ready=1 -> data_out=8'hA5, valid=1 exactly 10 edges after the start edge, then valid=0 next cycle.
2. Back-to-back frames 8'h3C then 8'hFF (stop at 0, start immediately after), ready held 1 -> two consecutive valid words 3C, FF, 10 cycles apart, no error pulses.
3. Frame 8'h01 with stop bit d=1 -> frame_err single-cycle pulse, valid stays 0, then the line returns to IDLE and the next good frame 8'h55 is received correctly.
4. ready=0, frames 8'h11 then 8'h22 -> valid=1 with data_out=8'h11, overrun pulse at the second stop edge, data_out remains 8'h11. Then ready=1 -> valid falls.
5. valid=1 (8'h11) and ready asserted exactly on the stop edge of frame 8'h22 -> data_out=8'h22, valid stays 1, overrun=0.
6. Assert rst asynchronously (between edges) during data bit 4 of a frame -> all outputs 0 immediately. After release, a fresh frame 8'h5A is received correctly.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/stop serial deserialiser with a one-entry valid/ready holding register
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   d         serial line, one bit per clock
//   data_out  received word, stable while valid
//   valid     data_out holds an unconsumed word
//   ready     consumer takes the word on an edge where valid & ready
//   frame_err one-cycle pulse, bad stop bit, frame discarded
//   overrun   one-cycle pulse, good frame arrived while the holding register was full and not draining
module serial_frame_rx #(
  parameter int DATA_BITS = 8,
  parameter logic START_LEVEL = 1'b1,
  parameter logic STOP_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int CW = $clog2(DATA_BITS + 1);
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d, bit_mask;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  assign bit_mask = {{(DATA_BITS-1){1'b0}}, 1'b1} << cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = valid_q & ~ready;
    ferr_d = 1'b0;
    ovr_d = 1'b0;
    case (state_q)
      IDLE: if (d == START_LEVEL) begin
        state_d = DATA;
        cnt_d = '0;
      end
      DATA: begin
        shift_d = d ? (shift_q | bit_mask) : (shift_q & ~bit_mask);
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: begin
        state_d = IDLE;
        if (d != STOP_LEVEL) ferr_d = 1'b1;
        else if (!valid_q || ready) begin
          // a drain and a load on the same edge keep valid high with the new word
          data_d = shift_q;
          valid_d = 1'b1;
        end else ovr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign data_out = data_q;
  assign valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun = ovr_q;
endmodule
